// File: rtl/iir_block_sequencer.sv
// Purpose : sequences one block of X samples through the IIR filter core and
//           writes the latency-aligned filter output into the Y buffer.
// Latency : start sampled at edge 0 -> first y_we in cycle 1+FILT_LAT
//           (+FLUSH_LEN) -> done pulse in cycle 1+L+FILT_LAT (+FLUSH_LEN).
// Backpressure: none; the buffers and the filter accept one sample per cycle.
//           start is ignored while a block is in flight; abort returns to IDLE.
//
// Optional feature macro: IIR_SEQ_FLUSH_EN
//   When defined, FLUSH_LEN zero samples are fed to the filter before each block.
//
// Ports:
//   i_clk, i_reset     clock and async active-low reset (also resets the filter)
//   i_start, i_abort   block request / cancel
//   i_len              block length, 0 or >2**AW clamps to 2**AW
//   o_x_addr, i_x_rdata   X buffer read port (combinational read)
//   o_filt_in, i_filt_out IIR filter data in / out
//   o_y_we, o_y_addr, o_y_wdata  Y buffer write port
//   o_busy, o_done, o_data_valid status to the register file
module iir_block_sequencer #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int FILT_LAT  = 8,
  parameter int FLUSH_LEN = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW:0]   i_len,
  output logic [AW-1:0] o_x_addr,
  input  logic [DW-1:0] i_x_rdata,
  output logic [DW-1:0] o_filt_in,
  input  logic [DW-1:0] i_filt_out,
  output logic          o_y_we,
  output logic [AW-1:0] o_y_addr,
  output logic [DW-1:0] o_y_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_data_valid
);

  localparam int BLEN = 2**AW;
  // Counter spans the longest block (flush + samples + drain) without wrapping.
  localparam int CW   = $clog2(FLUSH_LEN + BLEN + FILT_LAT + 2);
`ifdef IIR_SEQ_FLUSH_EN
  localparam int PRE  = FLUSH_LEN;
`else
  localparam int PRE  = 0;
`endif
  localparam logic [CW-1:0] C_PRE  = CW'(PRE);
  localparam logic [CW-1:0] C_LAT  = CW'(FILT_LAT);
  localparam logic [AW:0]   C_BLEN = (AW+1)'(BLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   r_len;
  logic          r_feed;
  logic [AW-1:0] r_x_addr;
  logic          r_y_we;
  logic [AW-1:0] r_y_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_data_valid;

  logic [AW:0]   w_len_clamp;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_feed_end;
  logic [CW-1:0] w_drain_end;
  logic [CW-1:0] w_wr_beg;
  logic          w_in_flush;
  logic          w_wr_nxt;
  state_t        w_nxt_state;

  assign w_len_clamp = (i_len == '0 || i_len > C_BLEN) ? C_BLEN : i_len;

  // r_cnt counts cycles since the first busy cycle; every phase boundary is
  // a fixed offset from zero, so the next state is a pure function of count.
  assign w_cnt_nxt   = r_cnt + CW'(1);
  assign w_feed_end  = C_PRE + CW'(r_len);
  assign w_drain_end = w_feed_end + C_LAT;
  assign w_wr_beg    = C_PRE + C_LAT;

`ifdef IIR_SEQ_FLUSH_EN
  assign w_in_flush = (w_cnt_nxt < C_PRE);
`else
  assign w_in_flush = 1'b0;
`endif

  // Sample k enters the filter at count PRE+k and emerges FILT_LAT later,
  // so the write window is [PRE+FILT_LAT, PRE+L+FILT_LAT).
  assign w_wr_nxt = (w_cnt_nxt >= w_wr_beg) && (w_cnt_nxt < w_drain_end);

  always_comb begin
    w_nxt_state = S_DONE;
    if (w_in_flush) begin
      w_nxt_state = S_FLUSH;
    end else if (w_cnt_nxt < w_feed_end) begin
      w_nxt_state = S_FEED;
    end else if (w_cnt_nxt < w_drain_end) begin
      w_nxt_state = S_DRAIN;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_feed       <= 1'b0;
      r_x_addr     <= '0;
      r_y_we       <= 1'b0;
      r_y_addr     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_feed   <= 1'b0;
          r_x_addr <= '0;
          r_y_we   <= 1'b0;
          r_y_addr <= '0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          if (i_start && !i_abort) begin
            r_len        <= w_len_clamp;
            r_cnt        <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b1;
`ifdef IIR_SEQ_FLUSH_EN
            r_state      <= S_FLUSH;
`else
            r_state      <= S_FEED;
            r_feed       <= 1'b1;
`endif
          end
        end

        S_FLUSH, S_FEED, S_DRAIN: begin
          if (i_abort) begin
            r_state  <= S_IDLE;
            r_feed   <= 1'b0;
            r_x_addr <= '0;
            r_y_we   <= 1'b0;
            r_y_addr <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_state  <= w_nxt_state;
            r_feed   <= (w_nxt_state == S_FEED);
            r_x_addr <= (w_nxt_state == S_FEED) ? AW'(w_cnt_nxt - C_PRE) : '0;
            r_y_we   <= w_wr_nxt;
            r_y_addr <= w_wr_nxt ? AW'(w_cnt_nxt - w_wr_beg) : '0;
            r_busy   <= (w_nxt_state != S_DONE);
            r_done   <= (w_nxt_state == S_DONE);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          if (!i_abort) begin
            r_data_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The X buffer reads combinationally, so the sample for x_addr is passed
  // straight through in the same cycle; zeros outside FEED flush/drain the filter.
  assign o_filt_in    = r_feed ? i_x_rdata : '0;
  assign o_x_addr     = r_x_addr;
  assign o_y_we       = r_y_we;
  assign o_y_addr     = r_y_addr;
  assign o_y_wdata    = i_filt_out;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_data_valid = r_data_valid;

endmodule

// File: tb/tb_iir_block_sequencer.sv
`timescale 1ns/1ps
module tb_iir_block_sequencer;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int FLAT = 8;
  localparam int FLEN = 16;
  localparam int BLEN = 32;
`ifdef IIR_SEQ_FLUSH_EN
  localparam int PRE = FLEN;
`else
  localparam int PRE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] x_addr, y_addr;
  logic [DW-1:0] x_rdata, filt_in, filt_out, y_wdata;
  logic          y_we, busy, done, data_valid;

  logic [DW-1:0] xmem [BLEN];
  logic [DW-1:0] pipe [FLAT];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;
  bit mon_on = 1'b0;
  int wr_rel[$];
  int wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int done_rel[$];
  int max_x;
  int flush_bad;

  // Stand-in filter: fixed arithmetic on a FILT_LAT-deep delay line.
  function automatic logic [DW-1:0] fmodel(input logic [DW-1:0] x);
    return x * 32'd3 + 32'h0000_1234;
  endfunction

  iir_block_sequencer #(.DW(DW), .AW(AW), .FILT_LAT(FLAT), .FLUSH_LEN(FLEN)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort), .i_len(len),
    .o_x_addr(x_addr), .i_x_rdata(x_rdata), .o_filt_in(filt_in), .i_filt_out(filt_out),
    .o_y_we(y_we), .o_y_addr(y_addr), .o_y_wdata(y_wdata),
    .o_busy(busy), .o_done(done), .o_data_valid(data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign x_rdata  = xmem[x_addr];
  assign filt_out = fmodel(pipe[FLAT-1]);

  always @(posedge clk) begin
    pipe[0] <= filt_in;
    for (int i = 1; i < FLAT; i++) pipe[i] <= pipe[i-1];
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (y_we) begin
        wr_rel.push_back(cyc - base);
        wr_addr.push_back(int'(y_addr));
        wr_data.push_back(y_wdata);
      end
      if (done) done_rel.push_back(cyc - base);
      if (busy && int'(x_addr) > max_x) max_x = int'(x_addr);
      if ((cyc - base) >= 1 && (cyc - base) <= PRE && (filt_in != '0 || y_we))
        flush_bad++;
    end
  end

  // Runs one block starting in relative cycle 0 and checks it against the
  // timeline derived from L, PRE and FLAT. abort_rel>0 asserts abort in that cycle.
  task automatic run_block(input int len_in, input int abort_rel, input bit restart,
                           input string tag);
    int L, win, exp_n, n_chk;
    L = (len_in == 0 || len_in > BLEN) ? BLEN : len_in;
    for (int j = 0; j < BLEN; j++) xmem[j] = $urandom;
    wr_rel.delete(); wr_addr.delete(); wr_data.delete(); done_rel.delete();
    max_x = 0; flush_bad = 0;
    @(posedge clk); #1;
    base = cyc; mon_on = 1'b1; start = 1'b1; len = (AW+1)'(len_in);
    win = 1 + PRE + L + FLAT + 3;
    for (int r = 1; r <= win; r++) begin
      @(posedge clk); #1;
      start = restart && (r == 4 + PRE || r == 1 + PRE + L + FLAT);
      abort = (abort_rel > 0 && r == abort_rel);
      if (abort_rel > 0 && r == abort_rel + 1) begin
        n_vec++;
        if (busy !== 1'b0 || y_we !== 1'b0 || filt_in !== '0) begin
          n_err++;
          $display("FAIL %s abort_idle: busy=%0b y_we=%0b filt_in=%h, required 0 0 0",
                   tag, busy, y_we, filt_in);
        end
      end
    end
    start = 1'b0; abort = 1'b0; mon_on = 1'b0;

    exp_n = L;
    if (abort_rel > 0) begin
      exp_n = abort_rel - (PRE + FLAT);
      if (exp_n < 0) exp_n = 0;
      if (exp_n > L) exp_n = L;
    end
    n_vec++;
    if (wr_rel.size() != exp_n) begin
      n_err++;
      $display("FAIL %s write_count: got %0d, required %0d", tag, wr_rel.size(), exp_n);
    end
    n_chk = (wr_rel.size() < exp_n) ? wr_rel.size() : exp_n;
    for (int j = 0; j < n_chk; j++) begin
      n_vec++;
      if (wr_rel[j] != 1 + PRE + FLAT + j || wr_addr[j] != j || wr_data[j] !== fmodel(xmem[j])) begin
        n_err++;
        $display("FAIL %s write[%0d]: cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                 tag, j, wr_rel[j], wr_addr[j], wr_data[j], 1 + PRE + FLAT + j, j, fmodel(xmem[j]));
      end
    end
    if (abort_rel > 0) begin
      n_vec++;
      if (done_rel.size() != 0 || data_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s abort_status: done pulses=%0d data_valid=%0b, required 0 0",
                 tag, done_rel.size(), data_valid);
      end
    end else begin
      n_vec++;
      if (done_rel.size() != 1 || done_rel[0] != 1 + PRE + L + FLAT) begin
        n_err++;
        $display("FAIL %s done_timing: pulses=%0d first=%0d, required 1 at %0d",
                 tag, done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1, 1 + PRE + L + FLAT);
      end
      n_vec++;
      if (data_valid !== 1'b1 || max_x != L - 1) begin
        n_err++;
        $display("FAIL %s valid_xaddr: data_valid=%0b max_x=%0d, required 1 %0d",
                 tag, data_valid, max_x, L - 1);
      end
    end
`ifdef IIR_SEQ_FLUSH_EN
    n_vec++;
    if (flush_bad != 0) begin
      n_err++;
      $display("FAIL %s flush_quiet: %0d bad cycles, required 0", tag, flush_bad);
    end
`endif
  endtask

  task automatic test_reset();
    start = 1'b1; len = 6'd7;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || data_valid !== 1'b0 || y_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: busy=%0b done=%0b dv=%0b y_we=%0b, required 0", busy, done, data_valid, y_we);
    end
    n_vec++;
    if (x_addr !== '0 || y_addr !== '0 || filt_in !== '0) begin
      n_err++;
      $display("FAIL reset_data: x_addr=%0d y_addr=%0d filt_in=%h, required 0", x_addr, y_addr, filt_in);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_full_block();
    run_block(32, 0, 1'b0, "full32");
  endtask

  task automatic test_short_block();
    run_block(5, 0, 1'b0, "len5");
  endtask

  task automatic test_clamp();
    run_block(0, 0, 1'b0, "len0");
    run_block(63, 0, 1'b0, "len63");
  endtask

  task automatic test_abort();
    run_block(32, 1 + PRE + 10, 1'b0, "abort_k10");
    run_block(32, 0, 1'b0, "after_abort");
    // start and abort together from IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; len = 6'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort_same: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_restart_ignored();
    run_block(32, 0, 1'b1, "restart");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_block(int'($urandom_range(1, 32)), 0, 1'b0, "rand_len");
  endtask

  task automatic test_reset_midblock();
    @(posedge clk); #1;
    start = 1'b1; len = 6'd32;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PRE + 14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || y_we !== 1'b0 || filt_in !== '0 || x_addr !== '0 || y_addr !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midblock: busy=%0b y_we=%0b filt_in=%h x_addr=%0d y_addr=%0d done=%0b, required all 0",
               busy, y_we, filt_in, x_addr, y_addr, done);
    end
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int j = 0; j < BLEN; j++) xmem[j] = '0;
    for (int i = 0; i < FLAT; i++) pipe[i] = '0;
    test_reset();
    test_full_block();
    test_short_block();
    test_clamp();
    test_abort();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midblock();
    run_block(7, 0, 1'b0, "post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
